write_back: RTL

WRITE_BACK -- requirements
Module: write_back

---
 rtl/write_back_pkg.sv | 26 ++
 rtl/wb_arbiter.sv | 39 +++
 rtl/write_back.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/write_back_pkg.sv
// Shared types and defaults for the write-back stage.
// No logic; constants and types only.
// Used by write_back and wb_arbiter.
package write_back_pkg;

  localparam int WB_XLEN         = 32;
  localparam int WB_FLUSH_CYCLES = 2;
  localparam int WB_STARVE_MAX   = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic               valid;
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

  // x0 is hardwired to zero, so an entry targeting it never writes or clears.
  function automatic logic wb_writes(input logic vld, input logic [4:0] rd);
    return vld && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/wb_arbiter.sv
// Two-input select between ALU and LSU entries; ALU wins unless the LSU has starved.
// Latency: combinational select; starve counter updates on the rising edge.
// Backpressure: the loser is simply not selected and must hold its entry.
module wb_arbiter
  import write_back_pkg::*;
#(
  parameter int STARVE_MAX = WB_STARVE_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic alu_vld,
  input  logic lsu_vld,
  output logic alu_sel,
  output logic lsu_sel
);

  localparam int              CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_q;
  logic          starved;

  assign starved = (starve_q == CNT_MAX);
  assign lsu_sel = en && lsu_vld && (!alu_vld || starved);
  assign alu_sel = en && alu_vld && !lsu_sel;

  // Count cycles the LSU waits; any cycle it is taken, drained or idle restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (!en || !lsu_vld || lsu_sel) begin
      starve_q <= '0;
    end else if (!starved) begin
      starve_q <= starve_q + 1'b1;
    end
  end

endmodule

// File: rtl/write_back.sv
// Write-back stage: retires one ALU or LSU entry per cycle, writes the RF, handles redirects.
// Latency: consume is same-cycle; RF/clear/redirect outputs follow one cycle later.
// Backpressure: alu_ok_o/lsu_ok_o acknowledge entries; during a flush both are held high to drain.
module write_back
  import write_back_pkg::*;
#(
  parameter int xlen         = WB_XLEN,
  parameter int FLUSH_CYCLES = WB_FLUSH_CYCLES,
  parameter int STARVE_MAX   = WB_STARVE_MAX
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid_i,
  input  logic            alu_result_valid_i,
  input  logic [4:0]      alu_rd_i,
  input  logic [xlen-1:0] alu_result_i,
  input  logic            alu_target_valid_i,
  input  logic [xlen-1:0] alu_target_i,
  output logic            alu_ok_o,
  input  logic            lsu_valid_i,
  input  logic [4:0]      lsu_rd_i,
  input  logic [xlen-1:0] lsu_data_i,
  output logic            lsu_ok_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [xlen-1:0] rf_wdata_o,
  output logic            clr_valid_o,
  output logic [4:0]      clr_rd_o,
  output logic            redirect_o,
  output logic [xlen-1:0] redirect_pc_o,
  output logic            flush_o,
  output logic [63:0]     instret_o
);

  localparam logic [2:0] FC_LAST = 3'(FLUSH_CYCLES - 1);

  wb_state_t       state_q, state_d;
  logic [2:0]      flush_cnt_q, flush_cnt_d;
  logic            arb_en, alu_sel, lsu_sel;
  logic            wr_vld, wr_en, retire, take_redirect;
  logic [4:0]      wr_rd;
  logic [xlen-1:0] wr_data;
  logic [63:0]     instret_q;

  assign arb_en    = (state_q == RUN);
  assign instret_o = instret_q;

  wb_arbiter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (arb_en),
    .alu_vld (alu_valid_i),
    .lsu_vld (lsu_valid_i),
    .alu_sel (alu_sel),
    .lsu_sel (lsu_sel)
  );

  // State and flush counter registers; reset aborts any flush in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state and handshake outputs: a taken redirect enters FLUSH, which drains both inputs.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    alu_ok_o    = 1'b0;
    lsu_ok_o    = 1'b0;
    flush_o     = 1'b0;
    case (state_q)
      RUN: begin
        alu_ok_o = alu_sel;
        lsu_ok_o = lsu_sel;
        if (alu_sel && alu_target_valid_i) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        flush_o  = 1'b1;
        alu_ok_o = 1'b1;
        lsu_ok_o = 1'b1;
        if (flush_cnt_q == FC_LAST) begin
          state_d     = RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 3'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Pick the write source; arbiter selects are exclusive and already gated off in FLUSH.
  always_comb begin
    wr_vld  = 1'b0;
    wr_rd   = '0;
    wr_data = '0;
    if (alu_sel && alu_result_valid_i) begin
      wr_vld  = 1'b1;
      wr_rd   = alu_rd_i;
      wr_data = alu_result_i;
    end else if (lsu_sel) begin
      wr_vld  = 1'b1;
      wr_rd   = lsu_rd_i;
      wr_data = lsu_data_i;
    end
    wr_en         = wb_writes(wr_vld, wr_rd);
    take_redirect = alu_sel && alu_target_valid_i;
    retire        = (alu_sel && (alu_result_valid_i || alu_target_valid_i)) || lsu_sel;
  end

  // Register the write, clear and redirect ports; idle fields are driven to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_o       <= 1'b0;
      rf_waddr_o    <= '0;
      rf_wdata_o    <= '0;
      clr_valid_o   <= 1'b0;
      clr_rd_o      <= '0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      rf_we_o       <= wr_en;
      rf_waddr_o    <= wr_en ? wr_rd : 5'd0;
      rf_wdata_o    <= wr_en ? wr_data : '0;
      clr_valid_o   <= wr_en;
      clr_rd_o      <= wr_en ? wr_rd : 5'd0;
      redirect_o    <= take_redirect;
      redirect_pc_o <= take_redirect ? alu_target_i : '0;
    end
  end

  // Retired-entry counter; wraps naturally at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 64'd1;
    end
  end

endmodule
